ddr_burst_sched: RTL and testbench

Burst scheduler directly downstream of the four-channel write/read priority arbiter in the audio/video DDR path. Latches the one-hot write or read grant when idle, alternates direction on contention, issues one fixed-length burst command per grant to the DDR controller, and steers beat enables back to the winning channel FIFO. Keeps a per-channel, per-direction beat pointer that advances by one burst per completion and wraps at frame end.

---
 rtl/ddr_sched_pkg.sv | 28 ++
 rtl/burst_ptr.sv | 33 +++
 rtl/ddr_burst_sched.sv | 150 +++++++++++++++
 tb/tb_ddr_burst_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sched_pkg.sv
// Shared types for the DDR burst scheduler: FSM states, direction encoding, channel indexing.
// Highest-set-bit encoder used to resolve multi-bit grants.
package ddr_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_RDATA,
      ST_DONE
   } state_t;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

   localparam int CH_W   = 2;
   localparam int NUM_CH = 4;

   function automatic logic [CH_W-1:0] hi_idx(input logic [NUM_CH-1:0] grant);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) idx = CH_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/burst_ptr.sv
// One per-channel, per-direction beat pointer: advances by one burst, wraps at frame end.
// Clear has priority over advance; updates take effect the cycle after the request.
module burst_ptr #(
   parameter int PTR_W       = 20,
   parameter int BURST_LEN   = 64,
   parameter int FRAME_BEATS = 2**20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   output logic [PTR_W-1:0] ptr
);

   // One extra bit so a frame of exactly 2**PTR_W beats is still detectable.
   localparam logic [PTR_W:0] STEP  = (PTR_W+1)'(BURST_LEN);
   localparam logic [PTR_W:0] FRAME = (PTR_W+1)'(FRAME_BEATS);

   logic [PTR_W:0] sum;

   assign sum = {1'b0, ptr} + STEP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= (sum == FRAME) ? '0 : sum[PTR_W-1:0];
      end
   end

endmodule

// File: rtl/ddr_burst_sched.sv
// Burst scheduler: latches an arbiter grant, issues one fixed-length command, steers beats to the winner.
// Command one cycle after grant, held until cmd_ready; beat enables follow DDR ready/valid combinationally.
module ddr_burst_sched
   import ddr_sched_pkg::*;
#(
   parameter int BURST_LEN   = 64,
   parameter int PTR_W       = 20,
   parameter int FRAME_BEATS = 2**20,
   parameter int LEN_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       wr_grant,
   input  logic [NUM_CH-1:0]       rd_grant,
   input  logic [NUM_CH-1:0]       wr_frame_rst,
   input  logic [NUM_CH-1:0]       rd_frame_rst,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic                    cmd_wr,
   output logic [PTR_W+CH_W-1:0]   cmd_addr,
   output logic [LEN_W-1:0]        cmd_len,
   input  logic                    ddr_wr_ready,
   input  logic                    ddr_rd_valid,
   output logic [NUM_CH-1:0]       ch_wr_en,
   output logic [NUM_CH-1:0]       ch_rd_en,
   output logic [NUM_CH-1:0]       burst_done,
   output logic                    busy
);

   localparam int               CNT_W     = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   state_t            state;
   logic              last_dir;
   logic [NUM_CH-1:0] sel;
   logic [CNT_W-1:0]  beat_cnt;

   logic [PTR_W-1:0]  wr_ptr [NUM_CH];
   logic [PTR_W-1:0]  rd_ptr [NUM_CH];
   logic [NUM_CH-1:0] wr_adv;
   logic [NUM_CH-1:0] rd_adv;

   logic              any_grant;
   logic              pick_dir;
   logic [CH_W-1:0]   pick_ch;
   logic [PTR_W-1:0]  pick_ptr;
   logic              beat;

   // On contention serve the direction that did not go last.
   always_comb begin
      any_grant = (|wr_grant) | (|rd_grant);
      if ((|wr_grant) && (|rd_grant)) begin
         pick_dir = ~last_dir;
      end else begin
         pick_dir = (|wr_grant) ? DIR_WR : DIR_RD;
      end
      pick_ch  = hi_idx((pick_dir == DIR_WR) ? wr_grant : rd_grant);
      pick_ptr = (pick_dir == DIR_WR) ? wr_ptr[pick_ch] : rd_ptr[pick_ch];
   end

   assign beat = ((state == ST_WDATA) && ddr_wr_ready) ||
                 ((state == ST_RDATA) && ddr_rd_valid);

   assign ch_wr_en = (state == ST_WDATA) ? (sel & {NUM_CH{ddr_wr_ready}}) : '0;
   assign ch_rd_en = (state == ST_RDATA) ? (sel & {NUM_CH{ddr_rd_valid}}) : '0;

   assign wr_adv = ((state == ST_DONE) && (cmd_wr == DIR_WR)) ? sel : '0;
   assign rd_adv = ((state == ST_DONE) && (cmd_wr == DIR_RD)) ? sel : '0;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ptr
      burst_ptr #(
         .PTR_W       (PTR_W),
         .BURST_LEN   (BURST_LEN),
         .FRAME_BEATS (FRAME_BEATS)
      ) u_wr_ptr (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (wr_frame_rst[i]),
         .adv   (wr_adv[i]),
         .ptr   (wr_ptr[i])
      );

      burst_ptr #(
         .PTR_W       (PTR_W),
         .BURST_LEN   (BURST_LEN),
         .FRAME_BEATS (FRAME_BEATS)
      ) u_rd_ptr (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (rd_frame_rst[i]),
         .adv   (rd_adv[i]),
         .ptr   (rd_ptr[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_dir   <= DIR_RD;
         sel        <= '0;
         beat_cnt   <= '0;
         cmd_valid  <= 1'b0;
         cmd_wr     <= 1'b0;
         cmd_addr   <= '0;
         cmd_len    <= '0;
         burst_done <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_grant) begin
                  sel       <= NUM_CH'(1) << pick_ch;
                  cmd_wr    <= pick_dir;
                  cmd_addr  <= {pick_ch, pick_ptr};
                  cmd_len   <= LEN_W'(BURST_LEN - 1);
                  cmd_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  beat_cnt  <= '0;
                  state     <= (cmd_wr == DIR_WR) ? ST_WDATA : ST_RDATA;
               end
            end
            ST_WDATA, ST_RDATA: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) begin
                     burst_done <= sel;
                     state      <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               burst_done <= '0;
               last_dir   <= cmd_wr;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Directed and randomized bursts checked against a per-channel pointer / direction model.
module tb_ddr_burst_sched;

   localparam int BL = 4;
   localparam int PW = 4;
   localparam int FB = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    wr_grant = '0, rd_grant = '0;
   logic [3:0]    wr_frame_rst = '0, rd_frame_rst = '0;
   logic          cmd_valid, cmd_ready = 1'b0, cmd_wr;
   logic [PW+1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic          ddr_wr_ready = 1'b0, ddr_rd_valid = 1'b0;
   logic [3:0]    ch_wr_en, ch_rd_en, burst_done;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: next beat pointer per [direction][channel], last served direction.
   int mptr [2][4];
   int mlast;

   ddr_burst_sched #(
      .BURST_LEN   (BL),
      .PTR_W       (PW),
      .FRAME_BEATS (FB),
      .LEN_W       (LW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_grant     (wr_grant),
      .rd_grant     (rd_grant),
      .wr_frame_rst (wr_frame_rst),
      .rd_frame_rst (rd_frame_rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_wr       (cmd_wr),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .ddr_wr_ready (ddr_wr_ready),
      .ddr_rd_valid (ddr_rd_valid),
      .ch_wr_en     (ch_wr_en),
      .ch_rd_en     (ch_rd_en),
      .burst_done   (burst_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk(tag, 32'({cmd_valid, cmd_wr, cmd_addr, cmd_len, ch_wr_en, ch_rd_en, burst_done, busy}), 32'd0);
   endtask

   function automatic void model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) mptr[d][c] = 0;
      mlast = 0;
   endfunction

   function automatic logic rnd_bit(input int mode);
      return (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   // Called at posedge+1 of an IDLE cycle with grants already driven; returns at posedge+1 of the next IDLE cycle.
   task automatic run_burst(input int mode, input bit frst);
      int         t, dir, ch, beats, guard, addr;
      logic       b, tog;
      logic [3:0] g;
      dir = (wr_grant != 0 && rd_grant != 0) ? 1 - mlast : ((wr_grant != 0) ? 1 : 0);
      g = (dir == 1) ? wr_grant : rd_grant;
      ch = 0;
      for (int i = 0; i < 4; i++) if (g[i]) ch = i;
      addr = ch * (2**PW) + mptr[dir][ch];

      t = 0;
      cmd_ready = rnd_bit(mode);
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      while (!cmd_valid && t < 20) begin
         @(posedge clk); #1;
         cmd_ready = rnd_bit(mode);
         @(negedge clk);
         t++;
      end
      chk("cmd_latency", t, 1);
      chk("cmd_wr", 32'(cmd_wr), dir);
      chk("cmd_addr", 32'(cmd_addr), addr);
      chk("cmd_len", 32'(cmd_len), BL - 1);
      chk("busy_cmd", 32'(busy), 32'd1);

      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(posedge clk); #1;
         cmd_ready = rnd_bit(mode);
         @(negedge clk);
         chk("cmd_hold_vld", 32'(cmd_valid), 32'd1);
         chk("cmd_hold_addr", 32'(cmd_addr), addr);
         guard++;
      end
      chk("cmd_accept", 32'(cmd_ready), 32'd1);

      @(posedge clk); #1;
      cmd_ready = 1'b0;
      beats = 0;
      guard = 0;
      tog = 1'b1;
      while (beats < BL && guard < 200) begin
         case (mode)
            0:       b = 1'b1;
            1:       begin b = tog; tog = ~tog; end
            default: b = 1'($urandom_range(0, 1));
         endcase
         if (dir == 1) begin
            ddr_wr_ready = b;
            ddr_rd_valid = 1'($urandom_range(0, 1));
         end else begin
            ddr_rd_valid = b;
            ddr_wr_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         chk("ch_wr_en", 32'(ch_wr_en), (dir == 1 && b) ? (1 << ch) : 0);
         chk("ch_rd_en", 32'(ch_rd_en), (dir == 0 && b) ? (1 << ch) : 0);
         chk("done_early", 32'(burst_done), 32'd0);
         chk("cmd_vld_data", 32'(cmd_valid), 32'd0);
         beats += (b ? 1 : 0);
         guard++;
         @(posedge clk); #1;
      end
      ddr_wr_ready = 1'b0;
      ddr_rd_valid = 1'b0;
      if (frst) begin
         if (dir == 1) wr_frame_rst = 4'(1 << ch);
         else          rd_frame_rst = 4'(1 << ch);
      end
      @(negedge clk);
      chk("burst_done", 32'(burst_done), 1 << ch);
      chk("busy_done", 32'(busy), 32'd1);
      chk("en_done", 32'({ch_wr_en, ch_rd_en}), 32'd0);
      mptr[dir][ch] = (mptr[dir][ch] + BL) % FB;
      if (frst) mptr[dir][ch] = 0;
      mlast = dir;
      @(posedge clk); #1;
      wr_frame_rst = '0;
      rd_frame_rst = '0;
   endtask

   initial begin
      logic [3:0] wg, rg;
      model_reset();

      // Reset state, during and after release.
      @(posedge clk); #1;
      @(negedge clk);
      chk_quiet("reset_hold");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_quiet("reset_release");
      @(posedge clk); #1;

      // Single write burst on channel 2.
      wr_grant = 4'b0100;
      run_burst(0, 1'b0);
      wr_grant = '0;

      // Three channel-0 writes: pointer 0, 4, then wrap to 0.
      wr_grant = 4'b0001;
      for (int i = 0; i < 3; i++) run_burst(0, 1'b0);
      wr_grant = '0;

      // Contention held from reset: write, read, write.
      wr_grant = 4'b0001;
      rd_grant = 4'b0010;
      do_reset();
      for (int i = 0; i < 3; i++) run_burst(0, 1'b0);
      wr_grant = '0;
      rd_grant = '0;

      // Toggling write ready.
      wr_grant = 4'b0010;
      run_burst(1, 1'b0);

      // Frame clear coinciding with DONE at pointer 0 beats the advance.
      run_burst(0, 1'b0);
      run_burst(0, 1'b1);
      run_burst(0, 1'b0);
      wr_grant = '0;

      // Raise ch2 write pointer, then reset mid-burst on beat 2.
      wr_grant = 4'b0100;
      run_burst(0, 1'b0);
      cmd_ready = 1'b1;
      ddr_wr_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_cmd_addr", 32'(cmd_addr), 2 * (2**PW) + mptr[1][2]);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_beat2_en", 32'(ch_wr_en), 32'h4);
      #1 rst_n = 1'b0;
      #1 chk_quiet("rst_async");
      @(negedge clk);
      chk_quiet("rst_next_edge");
      cmd_ready = 1'b0;
      ddr_wr_ready = 1'b0;
      @(posedge clk); #1;
      model_reset();
      rst_n = 1'b1;
      run_burst(0, 1'b0);
      wr_grant = '0;

      // Randomized grants, handshakes and beat gaps.
      for (int n = 0; n < 30; n++) begin
         do begin
            wg = 4'($urandom_range(0, 15));
            rg = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) wg = '0;
            else if ($urandom_range(0, 2) == 0) rg = '0;
         end while (wg == 0 && rg == 0);
         wr_grant = wg;
         rd_grant = rg;
         run_burst(2, ($urandom_range(0, 3) == 0));
      end
      wr_grant = '0;
      rd_grant = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
